gj_sequencer: RTL and testbench
===============================

# gj_sequencer

Command sequencer for the Gauss-Jordan matrix-inversion datapath. On `start` it walks an N×N inversion as an ordered stream of row operations (normalize pivot row, eliminate every other row) and issues them one at a time over a valid/ready handshake to the shared row-operation engine. That engine holds the A and I storage. The sequencer waits for each operation's response before issuing the next, then reports completion or singularity. It sits between the host/control logic and the row-op engine and replaces hard-coded elimination order.

## Interface
- `N`, 5, matrix dimension (rows); legal 2..8
- `RW`, 3, row-index width; must satisfy 2^RW ≥ N
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin an inversion; sampled only in IDLE
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the sequence ends (success or singular)
- `singular`  out  1  set with `done` if a zero pivot aborted the run; held until next accepted `start`
- `cmd_valid`  out  1  command present
- `cmd_ready`  in  1  engine accepts command
- `cmd_op`  out  2  0=NORM (row /= A[pivot][pivot]), 1=ELIM (row -= A[row][pivot]·pivot row), 2=SWAP (exchange pivot row and row), 3 unused
- `cmd_pivot`  out  RW  pivot row index p
- `cmd_row`  out  RW  target row (equals p for NORM)
- `rsp_valid`  in  1  engine finished the outstanding command
- `rsp_zero`  in  1  with `rsp_valid`: pivot element was zero (meaningful for NORM only)

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE → ISSUE on `start`. Set p=0, sub-step=NORM, clear `singular`, set `busy`.
- ISSUE: `cmd_valid`=1. `cmd_op`/`cmd_pivot`/`cmd_row` must stay stable until `cmd_valid && cmd_ready`. That handshake moves to WAIT.
- WAIT: ignore `rsp_valid` in any other state. On `rsp_valid`, advance to the next command and return to ISSUE, or finish.
- Per pivot p (0..N-1): NORM(p,p), then ELIM(p,r) for r = 0..N-1 ascending, skipping r=p. Total N² commands (25 for N=5).
- Finish after the response to ELIM(N-1,N-2): go to IDLE, pulse `done`, drop `busy`.
- NORM response with `rsp_zero`=1 follows the Configuration rules; `rsp_zero` on ELIM/SWAP is ignored.
- Only one command is outstanding at a time. `start` while busy is ignored.
- Reset values: `busy`=0, `done`=0, `singular`=0, `cmd_valid`=0, `cmd_op`=0, `cmd_pivot`=0, `cmd_row`=0; state IDLE.
- Reset mid-run aborts immediately with no `done`. The engine shares `reset` and must also abort.

## Timing
- `start` sampled at cycle 0 → ISSUE with `cmd_valid`=1 at cycle 1.
- Zero-wait engine (`cmd_ready`=1, `rsp_valid` in the first WAIT cycle): 2 cycles per command.
- For N=5 that gives the last `rsp_valid` at cycle 50, `done` at cycle 51, and `busy` high during cycles 1..50.
- `cmd_valid` deasserts the cycle after handshake. Next `cmd_valid` rises the cycle after `rsp_valid`.
- `done` and `singular` register in the same cycle. A new `start` is accepted in the cycle `done` is high (state already IDLE).

## Configuration
- `GJ_PIVOT_SWAP_EN` undefined: a NORM(p) response with `rsp_zero` aborts. Go to IDLE, pulse `done`, set `singular`=1.
- `GJ_PIVOT_SWAP_EN` defined: a zero NORM(p) triggers a search. Issue SWAP(p,s) for s=p+1, then reissue NORM(p,p). If that is zero again, advance s and repeat. Once s reaches N, abort as singular. Reset s to p+1 at each new pivot.
- Undefined: SWAP is never issued and `cmd_op` bit 1 is constant 0.

## Test plan
- Zero-wait engine, `rsp_zero`=0, N=5 → 25 commands in order NORM(0,0), ELIM(0,1..4), NORM(1,1), ELIM(1,0), ELIM(1,2..4) … ELIM(4,3); `done` at cycle 51; `singular`=0.
- `cmd_ready` held low 3 cycles on command 7 → `cmd_valid` and fields stable all 4 cycles; exactly one acceptance; done delayed by 3 cycles.
- Macro undefined, `rsp_zero`=1 on the 11th command NORM(2,2) → no 12th command; `done` pulse with `singular`=1; `busy` low next cycle.
- Macro defined, `rsp_zero`=1 on the first NORM(0,0) only → SWAP(0,1), NORM(0,0), then the normal sequence; 27 commands; `singular`=0.
- `start` pulsed during WAIT → ignored, command count unchanged. Stray `rsp_valid` in ISSUE → ignored.
- `reset` asserted in WAIT of command 10 → next cycle `cmd_valid`=0, `busy`=0, `done` never pulses; a fresh `start` then yields the full 25-command sequence.

Source files
------------

// File: rtl/gj_sequencer.sv
// gj_sequencer: issues the Gauss-Jordan row-operation stream for an N x N
// inversion to the shared row-op engine, one command at a time.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             begin an inversion (sampled only in IDLE)
//   busy              high while a sequence is in progress
//   done              one-cycle pulse at the end of a sequence
//   singular          set with done when a zero pivot aborted the run
//   cmd_valid/ready   command handshake to the engine
//   cmd_op            0=NORM, 1=ELIM, 2=SWAP
//   cmd_pivot/row     pivot row p and target row
//   rsp_valid/zero    engine completion, zero-pivot flag for NORM
//
// Build option: GJ_PIVOT_SWAP_EN enables the row-swap pivot search on a zero
// pivot; without it a zero pivot aborts the run as singular.
//
// state  | meaning
// S_IDLE | waiting for start
// S_ISSUE| cmd_valid high, holding fields until cmd_ready
// S_WAIT | command accepted, waiting for rsp_valid
module gj_sequencer #(
  parameter int N  = 5,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [1:0]    cmd_op,
  output logic [RW-1:0] cmd_pivot,
  output logic [RW-1:0] cmd_row,
  input  logic          rsp_valid,
  input  logic          rsp_zero
);

  localparam logic [1:0] OP_NORM = 2'd0;
  localparam logic [1:0] OP_ELIM = 2'd1;
`ifdef GJ_PIVOT_SWAP_EN
  localparam logic [1:0] OP_SWAP = 2'd2;
`endif
  localparam int CW = RW + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state;

`ifdef GJ_PIVOT_SWAP_EN
  // Candidate row for the next swap; one bit wider so it can reach N.
  logic [RW:0] swap_s;
`endif

  // Next ELIM target after cmd_row, skipping the pivot row. Computed wide so
  // the row+2 skip cannot wrap when N is a power of two.
  logic [CW-1:0] nxt_row;
  logic [CW-1:0] inc_row;
  logic          row_end;
  logic          last_pivot;
  logic [RW-1:0] first_elim;

  always_comb begin
    inc_row = {2'b00, cmd_row} + CW'(1);
    nxt_row = inc_row;
    if (inc_row == {2'b00, cmd_pivot})
      nxt_row = inc_row + CW'(1);
    row_end    = (nxt_row >= CW'(N));
    last_pivot = (cmd_pivot == RW'(N - 1));
    first_elim = (cmd_pivot == '0) ? RW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      singular  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= OP_NORM;
      cmd_pivot <= '0;
      cmd_row   <= '0;
`ifdef GJ_PIVOT_SWAP_EN
      swap_s    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ISSUE;
            busy      <= 1'b1;
            singular  <= 1'b0;
            cmd_valid <= 1'b1;
            cmd_op    <= OP_NORM;
            cmd_pivot <= '0;
            cmd_row   <= '0;
`ifdef GJ_PIVOT_SWAP_EN
            swap_s    <= (RW+1)'(1);
`endif
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            state     <= S_ISSUE;
            cmd_valid <= 1'b1;
            case (cmd_op)
              OP_NORM: begin
                if (rsp_zero) begin
`ifdef GJ_PIVOT_SWAP_EN
                  if (swap_s < (RW+1)'(N)) begin
                    cmd_op  <= OP_SWAP;
                    cmd_row <= swap_s[RW-1:0];
                  end else begin
                    state     <= S_IDLE;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    singular  <= 1'b1;
                  end
`else
                  state     <= S_IDLE;
                  cmd_valid <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  singular  <= 1'b1;
`endif
                end else begin
                  cmd_op  <= OP_ELIM;
                  cmd_row <= first_elim;
                end
              end
`ifdef GJ_PIVOT_SWAP_EN
              OP_SWAP: begin
                swap_s  <= swap_s + (RW+1)'(1);
                cmd_op  <= OP_NORM;
                cmd_row <= cmd_pivot;
              end
`endif
              default: begin
                if (row_end) begin
                  if (last_pivot) begin
                    state     <= S_IDLE;
                    cmd_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                  end else begin
                    cmd_op    <= OP_NORM;
                    cmd_pivot <= cmd_pivot + RW'(1);
                    cmd_row   <= cmd_pivot + RW'(1);
`ifdef GJ_PIVOT_SWAP_EN
                    swap_s    <= {1'b0, cmd_pivot} + (RW+1)'(2);
`endif
                  end
                end else begin
                  cmd_row <= nxt_row[RW-1:0];
                end
              end
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gj_sequencer.sv
// Testbench for gj_sequencer: table of scenarios plus randomized engine
// timing, checked against a command-list model built from the elimination
// order rules.
module tb_gj_sequencer;
  localparam int N  = 5;
  localparam int RW = 3;

  logic clk = 1'b0;
  logic reset, start, busy, done, singular, cmd_valid, cmd_ready;
  logic rsp_valid, rsp_zero;
  logic [1:0]    cmd_op;
  logic [RW-1:0] cmd_pivot, cmd_row;

  always #5 clk = ~clk;

  gj_sequencer #(.N(N), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .singular(singular), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pivot(cmd_pivot), .cmd_row(cmd_row),
    .rsp_valid(rsp_valid), .rsp_zero(rsp_zero)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { int op; int piv; int row; } cmd_t;
  cmd_t exp_q[$];
  bit   exp_sing_m;

  typedef struct {
    int stall_cmd; int stall_len; int zero_cmd;
    bit stray; bit start_wait; int reset_at; bit rnd; bit b2b;
    int exp_ncmd; int exp_sing; int exp_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected command list: per pivot NORM then ELIM of all other rows in
  // ascending order; a zero response on command number zero_cmd (1-based)
  // either aborts or inserts a swap with the next row and a retried NORM.
  task automatic build(input int zero_cmd);
    int k;
    exp_q.delete();
    exp_sing_m = 1'b0;
    k = 0;
    for (int p = 0; p < N; p++) begin
      exp_q.push_back('{0, p, p});
      k++;
      if (k == zero_cmd) begin
`ifdef GJ_PIVOT_SWAP_EN
        if (p + 1 < N) begin
          exp_q.push_back('{2, p, p + 1});
          exp_q.push_back('{0, p, p});
          k += 2;
        end else begin
          exp_sing_m = 1'b1;
          return;
        end
`else
        exp_sing_m = 1'b1;
        return;
`endif
      end
      for (int r = 0; r < N; r++) begin
        if (r != p) begin
          exp_q.push_back('{1, p, r});
          k++;
        end
      end
    end
  endtask

  task automatic run(input vec_t v, output bit sing_o);
    int   c, idx, wcnt, lat, stall_left;
    bit   pending, prev_hold, fin;
    cmd_t prev, e;
    build(v.zero_cmd);
    start = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_zero = 1'b0;
    step();
    start = 1'b0;
    c = 1; idx = 0; wcnt = 0; lat = 0; pending = 0; prev_hold = 0;
    stall_left = v.stall_len; fin = 0; sing_o = 0;
    prev = '{0, 0, 0};
    chk("singular cleared on start", singular, 0);
    while (!fin) begin
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_zero = 1'b0; start = 1'b0;
      if (c > 4000) begin
        chk("timeout", 0, 1);
        fin = 1;
      end else if (done) begin
        sing_o = singular;
        chk("busy low with done", busy, 0);
        chk("cmd_valid low with done", cmd_valid, 0);
        chk("cmd count vs model", idx, exp_q.size());
        chk("singular vs model", singular, exp_sing_m);
        if (v.exp_ncmd >= 0) chk("cmd count", idx, v.exp_ncmd);
        if (v.exp_sing >= 0) chk("singular", singular, v.exp_sing);
        if (v.exp_done >= 0) chk("done cycle", c, v.exp_done);
        fin = 1;
      end else begin
        chk("busy", busy, 1);
        if (cmd_valid) begin
          chk("valid while outstanding", pending, 0);
          if (prev_hold) begin
            chk("hold op", cmd_op, prev.op);
            chk("hold pivot", cmd_pivot, prev.piv);
            chk("hold row", cmd_row, prev.row);
          end
          if (v.stray) begin rsp_valid = 1'b1; rsp_zero = 1'b1; end
          if (idx + 1 == v.stall_cmd && stall_left > 0) begin
            stall_left--;
            cmd_ready = 1'b0;
          end else begin
            cmd_ready = v.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
          if (cmd_ready) begin
            if (idx < exp_q.size()) e = exp_q[idx];
            else e = '{-1, -1, -1};
            chk("cmd op", cmd_op, e.op);
            chk("cmd pivot", cmd_pivot, e.piv);
            chk("cmd row", cmd_row, e.row);
            idx++;
            pending = 1; wcnt = 0; prev_hold = 0;
            lat = v.rnd ? int'($urandom_range(0, 3)) : 0;
          end else begin
            prev_hold = 1;
            prev = '{int'(cmd_op), int'(cmd_pivot), int'(cmd_row)};
          end
        end else begin
          prev_hold = 0;
          if (pending) begin
            if (v.start_wait) start = 1'b1;
            if (v.reset_at == idx) begin
              reset = 1'b1;
              step();
              reset = 1'b0;
              for (int i = 0; i < 4; i++) begin
                chk("reset cmd_valid", cmd_valid, 0);
                chk("reset busy", busy, 0);
                chk("reset done", done, 0);
                step();
              end
              fin = 1;
            end else if (wcnt == lat) begin
              rsp_valid = 1'b1;
              rsp_zero  = (idx == v.zero_cmd);
              pending = 0;
            end else begin
              wcnt++;
            end
          end else begin
            chk("cmd_valid after rsp", cmd_valid, 1);
          end
        end
        if (!fin) begin
          step();
          c++;
        end
      end
    end
  endtask

  vec_t vecs[8];
  vec_t rv;
  bit   s_o;

  initial begin
    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_zero = 1'b0;
    step(); step(); step();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst singular", singular, 0);
    chk("rst cmd_valid", cmd_valid, 0);
    chk("rst cmd_op", cmd_op, 0);
    chk("rst cmd_pivot", cmd_pivot, 0);
    chk("rst cmd_row", cmd_row, 0);
    reset = 1'b0;
    step();

    //          stall  len zero str sw rst rnd b2b ncmd sing done
    vecs[0] = '{0,     0,  0,   0,  0, -1, 0,  0,  25,  0,   51};
    vecs[1] = '{7,     3,  0,   0,  0, -1, 0,  0,  25,  0,   54};
`ifdef GJ_PIVOT_SWAP_EN
    vecs[2] = '{0,     0,  11,  0,  0, -1, 0,  1,  27,  0,   55};
`else
    vecs[2] = '{0,     0,  11,  0,  0, -1, 0,  1,  11,  1,   23};
`endif
    vecs[3] = '{0,     0,  2,   0,  0, -1, 0,  0,  25,  0,   51};
    vecs[4] = '{0,     0,  0,   1,  1, -1, 0,  0,  25,  0,   51};
    vecs[5] = '{0,     0,  0,   0,  0, 10, 0,  0,  -1, -1,   -1};
    vecs[6] = '{0,     0,  0,   0,  0, -1, 0,  0,  25,  0,   51};
`ifdef GJ_PIVOT_SWAP_EN
    vecs[7] = '{0,     0,  1,   0,  0, -1, 0,  0,  27,  0,   55};
`else
    vecs[7] = '{0,     0,  1,   0,  0, -1, 0,  0,  1,   1,   3};
`endif

    for (int i = 0; i < 8; i++) begin
      run(vecs[i], s_o);
      if (!vecs[i].b2b) begin
        step();
        chk("done single pulse", done, 0);
        chk("idle busy", busy, 0);
        chk("idle cmd_valid", cmd_valid, 0);
        chk("singular held", singular, s_o);
      end
    end

    for (int i = 0; i < 20; i++) begin
      rv = '{0, 0, 0, 0, 0, -1, 1, 0, -1, -1, -1};
      rv.zero_cmd   = int'($urandom_range(0, 27));
      rv.stray      = 1'($urandom_range(0, 1));
      rv.start_wait = 1'($urandom_range(0, 1));
      rv.b2b        = 1'($urandom_range(0, 1));
      run(rv, s_o);
      if (!rv.b2b) begin
        step();
        chk("rnd done single pulse", done, 0);
        chk("rnd singular held", singular, s_o);
      end
    end
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
